// File: rtl/mul_seq_pkg.sv
// -----------------------------------------------------------------------------
// mul_seq_pkg
//   Shared constants and types for the sequential shift-add multiplier.
//   - LOGQ_DEFAULT : default residue width; the modulus is Q = 2^(LOGQ-1)+1.
//   - Q            : modulus for the default width.
//   - state_t      : 2-bit FSM encoding IDLE/BUSY/DONE.
//   - iters()      : BUSY-cycle count for a given width (LOGQ, or ceil(LOGQ/2)
//                    when the radix-4 build macro MUL_SEQ_RADIX4_EN is defined).
//   - ITERS        : iters() evaluated at the default width.
// -----------------------------------------------------------------------------
package mul_seq_pkg;

    localparam int LOGQ_DEFAULT = 17;
    localparam int unsigned Q   = (32'd1 << (LOGQ_DEFAULT - 1)) + 32'd1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int iters(input int logq);
`ifdef MUL_SEQ_RADIX4_EN
        return (logq + 1) / 2;
`else
        return logq;
`endif
    endfunction

    localparam int ITERS = iters(LOGQ_DEFAULT);

endpackage

// File: rtl/mul_seq_adder.sv
// -----------------------------------------------------------------------------
// adder
//   N-bit ripple-carry adder; the carry out of the top bit is discarded.
//   Ports:
//     a, b : N-bit addends
//     cin  : carry into bit 0
//     sum  : N-bit result (a + b + cin) mod 2^N
// -----------------------------------------------------------------------------
module adder #(
    parameter int N = 34
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum
);

    // carry[i] is the carry into bit i; no carry out of bit N-1 is formed.
    logic [N-1:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < N; i++) begin : g_bit
        assign sum[i] = a[i] ^ b[i] ^ carry[i];
        if (i < N - 1) begin : g_carry
            assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
    end

endmodule

// File: rtl/mul_seq.sv
// -----------------------------------------------------------------------------
// mul_seq
//   Sequential shift-add multiplier producing the exact 2*LOGQ-bit product of
//   two residues, feeding the modular reducer for Q = 2^(LOGQ-1)+1.
//   Build option: MUL_SEQ_RADIX4_EN consumes two multiplier bits per cycle
//   (ceil(LOGQ/2) iterations instead of LOGQ); interface and results are the
//   same in both builds.
//   Ports:
//     clk       : clock, rising edge
//     rst       : synchronous active-high reset
//     in_valid  : a/b operand pair valid
//     in_ready  : block accepts an operand pair this cycle
//     a, b      : LOGQ-bit multiplicand / multiplier
//     out_valid : p holds a completed product
//     out_ready : downstream consumes p this cycle
//     p         : 2*LOGQ-bit unreduced product, stable while out_valid=1
// -----------------------------------------------------------------------------
module mul_seq
    import mul_seq_pkg::*;
#(
    parameter int LOGQ = LOGQ_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [LOGQ-1:0]   a,
    input  logic [LOGQ-1:0]   b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*LOGQ-1:0] p
);

    localparam int W     = 2 * LOGQ;
    localparam int CW    = $clog2(LOGQ + 1);
    localparam int NITER = iters(LOGQ);

    state_t          state, next_state;
    logic [W-1:0]    a_sh;
    logic [LOGQ-1:0] b_sh;
    logic [W-1:0]    acc;
    logic [CW-1:0]   cnt;
    logic [W-1:0]    pp;
    logic [W-1:0]    acc_sum;
    logic            last;
    logic            accept;

    assign last   = (cnt == CW'(NITER - 1));
    assign accept = in_valid & in_ready;
    assign p      = acc;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of its neighbours.
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it
        // unassigned and infers a latch.
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) next_state = BUSY;
            end
            BUSY: begin
                if (last) next_state = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                // Consuming the result frees the block in the same cycle, so a
                // waiting pair is taken with no bubble.
                if (out_ready) begin
                    in_ready   = 1'b1;
                    next_state = in_valid ? BUSY : IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // ------------------------------------------------------ partial product
`ifdef MUL_SEQ_RADIX4_EN
    logic [W-1:0] a3_sh;
    logic [W-1:0] a_ext;
    logic [W-1:0] a3_init;

    assign a_ext = W'(a);

    // 3*a formed once at capture; it shifts alongside a_sh afterwards.
    adder #(.N(W)) u_adder_a3 (
        .a   (a_ext),
        .b   ({a_ext[W-2:0], 1'b0}),
        .cin (1'b0),
        .sum (a3_init)
    );

    always_comb begin
        unique case (b_sh[1:0])
            2'd0:    pp = '0;
            2'd1:    pp = a_sh;
            2'd2:    pp = {a_sh[W-2:0], 1'b0};
            default: pp = a3_sh;
        endcase
    end
`else
    assign pp = b_sh[0] ? a_sh : '0;
`endif

    adder #(.N(W)) u_adder_acc (
        .a   (acc),
        .b   (pp),
        .cin (1'b0),
        .sum (acc_sum)
    );

    // ------------------------------------------------------------ datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh <= '0;
            b_sh <= '0;
            acc  <= '0;
            cnt  <= '0;
`ifdef MUL_SEQ_RADIX4_EN
            a3_sh <= '0;
`endif
        end else if (accept) begin
            a_sh <= W'(a);
            b_sh <= b;
            acc  <= '0;
            cnt  <= '0;
`ifdef MUL_SEQ_RADIX4_EN
            a3_sh <= a3_init;
`endif
        end else if (state == BUSY) begin
            acc <= acc_sum;
            cnt <= cnt + CW'(1);
`ifdef MUL_SEQ_RADIX4_EN
            a_sh  <= {a_sh[W-3:0], 2'b00};
            a3_sh <= {a3_sh[W-3:0], 2'b00};
            b_sh  <= {2'b00, b_sh[LOGQ-1:2]};
`else
            a_sh <= {a_sh[W-2:0], 1'b0};
            b_sh <= {1'b0, b_sh[LOGQ-1:1]};
`endif
        end
    end

endmodule

// File: tb/tb_mul_seq.sv
// -----------------------------------------------------------------------------
// tb_mul_seq
//   Self-checking bench for mul_seq at LOGQ=17 (Q=65537). Expected products are
//   plain a*b; expected latency is LOGQ (or ceil(LOGQ/2) in the radix-4 build).
// -----------------------------------------------------------------------------
module tb_mul_seq;

    localparam int LOGQ = 17;
    localparam int W    = 2 * LOGQ;
`ifdef MUL_SEQ_RADIX4_EN
    localparam int LAT = (LOGQ + 1) / 2;
`else
    localparam int LAT = LOGQ;
`endif
    localparam int QM1 = 65536;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [LOGQ-1:0] a;
    logic [LOGQ-1:0] b;
    logic            out_valid;
    logic            out_ready;
    logic [W-1:0]    p;

    int n_cmp = 0;
    int n_bad = 0;

    mul_seq #(.LOGQ(LOGQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are then settled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] model(input logic [LOGQ-1:0] x, input logic [LOGQ-1:0] y);
        return 64'(x) * 64'(y);
    endfunction

    // Single transaction from IDLE with out_ready held high.
    task automatic run_one(input string tag, input logic [LOGQ-1:0] x, input logic [LOGQ-1:0] y);
        int k;
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        a         = x;
        b         = y;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();                       // acceptance edge E0
        in_valid = 1'b0;
        a        = LOGQ'($urandom);   // must be ignored
        b        = LOGQ'($urandom);
        k = 0;
        while (!out_valid && k < 100) begin
            tick();
            k++;
        end
        check({tag, "_latency"}, 64'(k), 64'(LAT));
        check({tag, "_p"}, 64'(p), model(x, y));
        tick();                       // consumed
        check({tag, "_drained"}, 64'(out_valid), 64'd0);
    endtask

    logic [LOGQ-1:0] sa [100];
    logic [LOGQ-1:0] sb [100];
    logic [63:0]     exp_q[$];

    initial begin : main
        int           seen;
        int           k;
        int           idx;
        int           got_n;
        int           cyc;
        logic [W-1:0] held;
        logic         fire_in;
        logic         fire_out;

        #2_000_000;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1);
    end

    initial begin : stim
        int           seen;
        int           k;
        int           idx;
        int           got_n;
        int           cyc;
        logic [W-1:0] held;
        logic         fire_in;
        logic         fire_out;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        tick(); tick();
        rst = 1'b0;

        // Reset state and idle quiet period.
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_p", 64'(p), 64'd0);
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (out_valid) seen++;
        end
        check("idle_no_output", 64'(seen), 64'd0);

        // Basic and corner products.
        run_one("basic_3x5", 17'd3, 17'd5);
        run_one("corner_max_max", 17'(QM1), 17'(QM1));
        run_one("corner_zero_max", 17'd0, 17'(QM1));
        run_one("corner_max_one", 17'(QM1), 17'd1);

        // Backpressure: hold result 5 cycles, then hand over and accept 7*9.
        a = 17'd11; b = 17'd13; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        k = 0;
        while (!out_valid && k < 100) begin tick(); k++; end
        check("bp_latency", 64'(k), 64'(LAT));
        held = p;
        check("bp_p", 64'(held), 64'd143);
        a = 17'd7; b = 17'd9; in_valid = 1'b1;   // ignored while in_ready=0
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold_valid", 64'(out_valid), 64'd1);
            check("bp_hold_p", 64'(p), 64'(held));
            check("bp_hold_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        k = 0;
        while (!out_valid && k < 100) begin tick(); k++; end
        check("bp_next_latency", 64'(k), 64'(LAT));
        check("bp_next_p", 64'(p), 64'd63);
        tick();

        // Random stream with random backpressure.
        for (int i = 0; i < 100; i++) begin
            sa[i] = (i % 10 == 3) ? 17'(QM1) : 17'($urandom_range(0, QM1));
            sb[i] = (i % 10 == 7) ? 17'(QM1) : 17'($urandom_range(0, QM1));
        end
        idx = 0; got_n = 0; cyc = 0;
        while (got_n < 100 && cyc < 20000) begin
            in_valid  = (idx < 100);
            a         = (idx < 100) ? sa[idx] : 17'($urandom);
            b         = (idx < 100) ? sb[idx] : 17'($urandom);
            out_ready = (idx < 100) ? 1'($urandom) : 1'b1;
            @(negedge clk);
            fire_in  = in_valid & in_ready;
            fire_out = out_valid & out_ready;
            if (fire_out) begin
                if (exp_q.size() == 0) begin
                    check("stream_spurious", 64'(p), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    check("stream_p", 64'(p), exp_q.pop_front());
                end
                got_n++;
            end
            if (fire_in) begin
                exp_q.push_back(model(sa[idx], sb[idx]));
                idx++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        check("stream_count", 64'(got_n), 64'd100);
        check("stream_leftover", 64'(exp_q.size()), 64'd0);
        in_valid = 1'b0; out_ready = 1'b1;
        tick();

        // Reset mid-operation at BUSY cycle 8.
        a = 17'd1000; b = 17'd1000; in_valid = 1'b1;
        tick();                       // E0; BUSY cycle 1 follows
        in_valid = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_p", 64'(p), 64'd0);
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (out_valid) seen++;
        end
        check("midrst_no_pulse", 64'(seen), 64'd0);
        run_one("after_rst_2x2", 17'd2, 17'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
